// File: rtl/ptf_mem_port_pkg.sv
// ptf_mem_port_pkg: shared widths, FSM encoding and address-mapping helper for ptf_mem_port
package ptf_mem_port_pkg;
  localparam int LOG_WIDTH = 10;
  localparam int LOG_HEIGHT = 9;
  localparam int LOG_MEM = 36;
  localparam int LOG_ADDR = 19;
  typedef enum logic [2:0] {IDLE, ADDR, REQ, LAT, DONE} state_t;
  function automatic bit is_pow2(input int v);
    return v > 0 && (v & (v - 1)) == 0;
  endfunction
endpackage

// File: rtl/ptf_addr_gen.sv
// ptf_addr_gen: pixel (x,y) to SRAM word address plus out-of-frame flag; flag active only with `PTF_BOUNDS_CHECK_EN
module ptf_addr_gen
  import ptf_mem_port_pkg::*;
#(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int BASE_ADDR = 0
) (
  input  logic [LOG_WIDTH-1:0]  x,
  input  logic [LOG_HEIGHT-1:0] y,
  output logic [LOG_ADDR-1:0]   addr,
  output logic                  oob
);
  localparam int HALF = WIDTH / 2;
  localparam int HI = $clog2(HALF + 1) - 1;
  localparam int REM = HALF - (1 << HI);
`ifdef PTF_BOUNDS_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  logic [LOG_ADDR-1:0] yw, row;
  assign yw = LOG_ADDR'(y);
  // y*WIDTH/2 as one or two shifts when the row pitch allows it
  if (REM == 0) begin : g_one
    assign row = yw << HI;
  end else if (is_pow2(REM)) begin : g_two
    assign row = (yw << HI) + (yw << $clog2(REM));
  end else begin : g_mul
    assign row = yw * LOG_ADDR'(HALF);
  end
  assign addr = LOG_ADDR'(BASE_ADDR) + row + LOG_ADDR'(x >> 1);
  assign oob = CHECK && (int'(x) >= WIDTH || int'(y) >= HEIGHT);
endmodule

// File: rtl/ptf_mem_port.sv
// ptf_mem_port: pixel-pair fetcher request port onto the shared ZBT SRAM bus; `PTF_BOUNDS_CHECK_EN drops out-of-frame requests
module ptf_mem_port
  import ptf_mem_port_pkg::*;
#(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int BASE_ADDR = 0,
  parameter int MEM_LAT = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ptf_flag,
  input  logic                  ptf_wr,
  input  logic [LOG_WIDTH-1:0]  ptf_x,
  input  logic [LOG_HEIGHT-1:0] ptf_y,
  input  logic [LOG_MEM-1:0]    ptf_pixel_write,
  output logic [LOG_MEM-1:0]    ptf_pixel_read,
  output logic                  done_ptf,
  output logic                  mem_req,
  input  logic                  mem_grant,
  output logic [LOG_ADDR-1:0]   mem_addr,
  output logic                  mem_we,
  output logic [LOG_MEM-1:0]    mem_wdata,
  output logic                  mem_wdata_en,
  input  logic [LOG_MEM-1:0]    mem_rdata
);
  state_t state, next;
  logic [LOG_WIDTH-1:0] x;
  logic [LOG_HEIGHT-1:0] y;
  logic wr;
  logic [LOG_MEM-1:0] wdata;
  logic [1:0] cnt;
  logic [LOG_ADDR-1:0] addr;
  logic oob, accept, data_ph;

  ptf_addr_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .BASE_ADDR(BASE_ADDR)) u_addr_gen (
    .x(x),
    .y(y),
    .addr(addr),
    .oob(oob)
  );

  // next state and bus/handshake outputs decoded from the current state
  always_comb begin
    done_ptf = state == IDLE || state == DONE;
    accept = done_ptf && ptf_flag;
    data_ph = state == LAT && cnt == 2'(MEM_LAT);
    mem_req = state == REQ;
    mem_we = mem_req && mem_grant && wr;
    mem_wdata_en = data_ph && wr;
    mem_wdata = mem_wdata_en ? wdata : '0;
    next = state;
    case (state)
      IDLE, DONE: next = accept ? ADDR : IDLE;
      ADDR:       next = oob ? DONE : REQ;
      REQ:        next = mem_grant ? LAT : REQ;
      LAT:        next = data_ph ? DONE : LAT;
      default:    next = IDLE;
    endcase
  end

  // state register; reset aborts any in-flight request
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;

  // request latch, registered word address, latency count from the address phase, read capture
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      x <= '0;
      y <= '0;
      wr <= 1'b0;
      wdata <= '0;
      cnt <= '0;
      mem_addr <= '0;
      ptf_pixel_read <= '0;
    end else begin
      if (accept) begin
        x <= ptf_x;
        y <= ptf_y;
        wr <= ptf_wr;
        wdata <= ptf_pixel_write;
      end
      if (state == ADDR && !oob) mem_addr <= addr;
      cnt <= state == REQ ? 2'd1 : cnt + 2'd1;
      if (data_ph && !wr) ptf_pixel_read <= mem_rdata;
    end
endmodule

// File: tb/tb_ptf_mem_port.sv
// tb_ptf_mem_port: scoreboard bench for ptf_mem_port; expects dropped out-of-frame requests when PTF_BOUNDS_CHECK_EN is defined
`timescale 1ns/1ps
module tb_ptf_mem_port;
  localparam int WIDTH = 640;
  localparam int HEIGHT = 480;
  localparam int BASE_ADDR = 0;
  localparam int MEM_LAT = 2;
`ifdef PTF_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  typedef struct {
    int acc;
    logic [18:0] addr;
    logic we;
    logic [35:0] data;
    int stall;
  } aph_t;
  typedef struct {
    int cyc;
    logic [35:0] pix;
  } done_t;

  logic clock = 1'b0, reset = 1'b0, ptf_flag = 1'b0, ptf_wr = 1'b0;
  logic [9:0] ptf_x = '0;
  logic [8:0] ptf_y = '0;
  logic [35:0] ptf_pixel_write = '0, ptf_pixel_read, mem_wdata, mem_rdata;
  logic done_ptf, mem_req, mem_grant, mem_we, mem_wdata_en;
  logic [18:0] mem_addr;

  aph_t aq[$];
  done_t dq[$];
  aph_t cur;
  done_t d;
  bit busy = 0, prev_done = 0;
  int aph = 0, cyc = 0, req_cyc = 0, stall_cfg = 0, checks = 0, errors = 0, last_acc = 0;
  logic [35:0] last_rd = '0;

  ptf_mem_port #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .BASE_ADDR(BASE_ADDR), .MEM_LAT(MEM_LAT)) dut (
    .clock(clock),
    .reset(reset),
    .ptf_flag(ptf_flag),
    .ptf_wr(ptf_wr),
    .ptf_x(ptf_x),
    .ptf_y(ptf_y),
    .ptf_pixel_write(ptf_pixel_write),
    .ptf_pixel_read(ptf_pixel_read),
    .done_ptf(done_ptf),
    .mem_req(mem_req),
    .mem_grant(mem_grant),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_wdata_en(mem_wdata_en),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // bus model: grant after stall_cfg request cycles (always granted when 0), read data only in the data phase
  assign mem_grant = stall_cfg == 0 || req_cyc >= stall_cfg;
  assign mem_rdata = (busy && !cur.we && cyc == aph + MEM_LAT) ? cur.data : 36'h5A5A5A5A5;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    req_cyc <= (mem_req && !mem_grant) ? req_cyc + 1 : 0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor: pops expected address phases and completions as the DUT produces them
  always @(negedge clock) begin
    if (reset) begin
      if (busy && cyc > aph + MEM_LAT) busy = 0;
      check("we_outside_aph", mem_we && !(mem_req && mem_grant), 0);
      check("wdata_en_timing", mem_wdata_en, busy && cur.we && cyc == aph + MEM_LAT);
      if (mem_wdata_en) check("wdata", mem_wdata, cur.data);
      if (mem_req && mem_grant) begin
        if (aq.size() == 0) check("extra_request", 1, 0);
        else begin
          cur = aq.pop_front();
          check("addr", mem_addr, cur.addr);
          check("we", mem_we, cur.we);
          check("aph_cycle", cyc - cur.acc, 2 + cur.stall);
          busy = 1;
          aph = cyc;
        end
      end
      if (done_ptf && !prev_done) begin
        if (dq.size() == 0) check("extra_done", 1, 0);
        else begin
          d = dq.pop_front();
          check("done_cycle", cyc, d.cyc);
          check("pixel_read", ptf_pixel_read, d.pix);
        end
      end
    end
    prev_done = done_ptf;
  end

  task automatic issue(input logic wr, input int x, input int y, input logic [35:0] data,
                       input int stall, input int hold);
    int t = 0;
    while (!done_ptf && t < 50) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (t == 50) check("ready_timeout", done_ptf, 1);
    stall_cfg = stall;
    ptf_flag = 1'b1;
    ptf_wr = wr;
    ptf_x = 10'(x);
    ptf_y = 9'(y);
    ptf_pixel_write = data;
    last_acc = cyc;
    if (BOUNDS && (x >= WIDTH || y >= HEIGHT)) dq.push_back('{cyc + 2, last_rd});
    else begin
      aq.push_back('{cyc, 19'(BASE_ADDR + y * (WIDTH / 2) + x / 2), wr, data, stall});
      if (!wr) last_rd = data;
      dq.push_back('{cyc + 3 + MEM_LAT + stall, last_rd});
    end
    @(posedge clock);
    #1;
    check("done_fall", done_ptf, 0);
    repeat (hold) begin
      @(posedge clock);
      #1;
    end
    ptf_flag = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((aq.size() != 0 || dq.size() != 0) && t < 100) begin
      @(posedge clock);
      #1;
      t++;
    end
    check("drain", aq.size() + dq.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, done_ptf, 1);
    check({tag, "_req"}, mem_req, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_wen"}, mem_wdata_en, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_pixel"}, ptf_pixel_read, 0);
    check({tag, "_addr"}, mem_addr, 0);
  endtask

  initial begin
    int a1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    check_reset_outputs("rst");
    issue(0, 5, 3, 36'h123456789, 0, 0);
    drain();
    issue(1, 639, 479, 36'hABCDE0123, 3, 0);
    drain();
    issue(0, 640, 0, 36'h0F0F0F0F0, 0, 0);
    drain();
    issue(1, 2, 480, 36'h111111111, 0, 0);
    drain();
    issue(0, 300, 200, 36'hFEDCBA987, 1, 0);
    drain();
    issue(0, 10, 20, 36'h777777777, 0, 0);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    aq.delete();
    dq.delete();
    busy = 0;
    last_rd = '0;
    @(posedge clock);
    #1 reset = 1'b1;
    issue(0, 1, 1, 36'h2468ACE01, 0, 0);
    drain();
    issue(0, 100, 50, 36'h13579BDF0, 0, 0);
    a1 = last_acc;
    issue(1, 101, 51, 36'h0A0B0C0D0, 0, 0);
    check("b2b_accept", last_acc - a1, 3 + MEM_LAT);
    drain();
    issue(0, 7, 7, 36'h0CAFEF00D, 0, 3);
    drain();
    repeat (5) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
